// File: rtl/regfile_mp.sv
// Parametrised multi-read-port register file with write-to-read bypass and a
// post-reset clear walk. Define RF_SCOREBOARD_EN to add the pending scoreboard.
module regfile_mp #(
  parameter int XLEN   = 32,
  parameter int NREG   = 32,
  parameter int AWIDTH = 5,
  parameter int NRD    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  init_done,
  input  logic                  we,
  input  logic [AWIDTH-1:0]     waddr,
  input  logic [XLEN-1:0]       wdata,
  input  logic [NRD*AWIDTH-1:0] raddr,
`ifdef RF_SCOREBOARD_EN
  output logic [NRD*XLEN-1:0]   rdata,
  input  logic                  sb_set,
  input  logic [AWIDTH-1:0]     sb_addr,
  output logic [NRD-1:0]        rd_pending
`else
  output logic [NRD*XLEN-1:0]   rdata
`endif
);

  typedef enum logic {
    CLEAR,
    READY
  } state_e;

  state_e              state_q, state_d;
  logic [AWIDTH-1:0]   clrIdx_q, clrIdx_d;
  logic                initDone_q, initDone_d;
  logic [XLEN-1:0]     regs_q [NREG];

  logic                wrEn;
  logic [AWIDTH-1:0]   wrAddr;
  logic [XLEN-1:0]     wrData;
  logic                extWrite;

  assign init_done = initDone_q;
  assign extWrite  = (state_q == READY) && we && (waddr != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= CLEAR;
      clrIdx_q   <= AWIDTH'(1);
      initDone_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      clrIdx_q   <= clrIdx_d;
      initDone_q <= initDone_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    clrIdx_d   = clrIdx_q;
    initDone_d = initDone_q;
    case (state_q)
      CLEAR: begin
        clrIdx_d = clrIdx_q + AWIDTH'(1);
        if (clrIdx_q == AWIDTH'(NREG - 1)) begin
          state_d    = READY;
          initDone_d = 1'b1;
        end
      end
      READY: begin
        state_d = READY;
      end
      default: begin
        state_d = CLEAR;
      end
    endcase
  end

  // The clear walk owns the single write port while CLEAR; external writes are dropped.
  always_comb begin
    wrEn   = 1'b0;
    wrAddr = waddr;
    wrData = wdata;
    if (!rst) begin
      if (state_q == CLEAR) begin
        wrEn   = 1'b1;
        wrAddr = clrIdx_q;
        wrData = '0;
      end else if (extWrite) begin
        wrEn = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wrEn) begin
      regs_q[wrAddr] <= wrData;
    end
  end

  for (genvar i = 0; i < NRD; i++) begin : gRead
    logic [AWIDTH-1:0] ra;
    logic [XLEN-1:0]   rd;

    assign ra = raddr[i*AWIDTH +: AWIDTH];

    always_comb begin
      rd = regs_q[ra];
      if (ra == '0 || state_q == CLEAR) begin
        rd = '0;
      end else if (we && waddr == ra) begin
        rd = wdata;
      end
    end

    assign rdata[i*XLEN +: XLEN] = rd;
  end

`ifdef RF_SCOREBOARD_EN
  logic [NREG-1:0] pend_q, pend_d;

  // A set and a write to the same register in one cycle leave it pending.
  always_comb begin
    pend_d = pend_q;
    if (state_q == READY) begin
      if (extWrite) begin
        pend_d[waddr] = 1'b0;
      end
      if (sb_set && sb_addr != '0) begin
        pend_d[sb_addr] = 1'b1;
      end
    end else begin
      pend_d = '0;
    end
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q <= '0;
    end else begin
      pend_q <= pend_d;
    end
  end

  for (genvar i = 0; i < NRD; i++) begin : gPend
    logic [AWIDTH-1:0] ra;
    logic              inFlight;

    assign ra            = raddr[i*AWIDTH +: AWIDTH];
    assign inFlight      = we && (waddr == ra) && (ra != '0);
    assign rd_pending[i] = pend_q[ra] && !inFlight;
  end
`endif

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: default instance plus a 3-port 64-bit 16-entry instance.
module tb_regfile_mp;

  typedef struct {
    string       tag;
    logic [63:0] exp;
  } exp_t;

  logic        clk;
  logic        rst;

  logic        initDone;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [9:0]  raddr;
  logic [63:0] rdata;

  logic         initDone3;
  logic         we3;
  logic [3:0]   waddr3;
  logic [63:0]  wdata3;
  logic [11:0]  raddr3;
  logic [191:0] rdata3;

`ifdef RF_SCOREBOARD_EN
  logic        sbSet;
  logic [4:0]  sbAddr;
  logic [1:0]  rdPending;
  logic        sbSet3;
  logic [3:0]  sbAddr3;
  logic [2:0]  rdPending3;
`endif

  exp_t sbQ[$];
  int   checks   = 0;
  int   failures = 0;

  regfile_mp dut (
    .clk       (clk),
    .rst       (rst),
    .init_done (initDone),
    .we        (we),
    .waddr     (waddr),
    .wdata     (wdata),
    .raddr     (raddr),
`ifdef RF_SCOREBOARD_EN
    .rdata     (rdata[63:0]),
    .sb_set    (sbSet),
    .sb_addr   (sbAddr),
    .rd_pending(rdPending)
`else
    .rdata     (rdata[63:0])
`endif
  );

  regfile_mp #(.XLEN(64), .NREG(16), .AWIDTH(4), .NRD(3)) dut3 (
    .clk       (clk),
    .rst       (rst),
    .init_done (initDone3),
    .we        (we3),
    .waddr     (waddr3),
    .wdata     (wdata3),
    .raddr     (raddr3),
`ifdef RF_SCOREBOARD_EN
    .rdata     (rdata3),
    .sb_set    (sbSet3),
    .sb_addr   (sbAddr3),
    .rd_pending(rdPending3)
`else
    .rdata     (rdata3)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic expectValue(input string tag, input logic [63:0] value);
    exp_t e;
    e.tag = tag;
    e.exp = value;
    sbQ.push_back(e);
  endtask

  task automatic checkOutput(input logic [63:0] observed);
    exp_t e;
    checks++;
    if (sbQ.size() == 0) begin
      failures++;
      $error("[TB] FAIL empty_queue observed=%h expected=<none>", observed);
    end else begin
      e = sbQ.pop_front();
      assert (observed === e.exp)
      else begin
        failures++;
        $error("[TB] FAIL %s observed=%h expected=%h", e.tag, observed, e.exp);
      end
    end
  endtask

  task automatic applyStimulus(input logic weV, input logic [4:0] wa, input logic [31:0] wd,
                               input logic [4:0] ra0, input logic [4:0] ra1);
    we    = weV;
    waddr = wa;
    wdata = wd;
    raddr = {ra1, ra0};
  endtask

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst    = 1'b1;
    we3    = 1'b0;
    waddr3 = '0;
    wdata3 = '0;
    raddr3 = '0;
    applyStimulus(1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
`ifdef RF_SCOREBOARD_EN
    sbSet   = 1'b0;
    sbAddr  = '0;
    sbSet3  = 1'b0;
    sbAddr3 = '0;
`endif

    // Reset for two edges, then walk the clear sequence edge by edge.
    @(negedge clk);
    cycle();
    cycle();
    expectValue("reset_init_done", 64'd0);
    checkOutput({63'd0, initDone});
    expectValue("reset_init_done3", 64'd0);
    checkOutput({63'd0, initDone3});
    rst = 1'b0;

    for (int k = 1; k <= 31; k++) begin
      if (k == 10) begin
        applyStimulus(1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd0);
        #1;
        expectValue("clear_read_x5", 64'd0);
        checkOutput({32'd0, rdata[31:0]});
      end
      expectValue($sformatf("init_done_edge%0d", k), (k >= 31) ? 64'd1 : 64'd0);
      if (k <= 16) expectValue($sformatf("init_done3_edge%0d", k), (k >= 15) ? 64'd1 : 64'd0);
      cycle();
      applyStimulus(1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
      checkOutput({63'd0, initDone});
      if (k <= 16) checkOutput({63'd0, initDone3});
    end

    applyStimulus(1'b0, 5'd0, 32'h0, 5'd5, 5'd0);
    #1;
    expectValue("x5_after_clear", 64'h0);
    checkOutput({32'd0, rdata[31:0]});

    // Basic writes and reads, including the hardwired zero register.
    applyStimulus(1'b1, 5'd7, 32'h12345678, 5'd0, 5'd0);
    cycle();
    applyStimulus(1'b1, 5'd31, 32'hFFFFFFFF, 5'd0, 5'd0);
    cycle();
    applyStimulus(1'b0, 5'd0, 32'h0, 5'd7, 5'd31);
    #1;
    expectValue("read_x7", 64'h12345678);
    expectValue("read_x31", 64'hFFFFFFFF);
    checkOutput({32'd0, rdata[31:0]});
    checkOutput({32'd0, rdata[63:32]});

    applyStimulus(1'b1, 5'd0, 32'hAAAA5555, 5'd0, 5'd0);
    #1;
    expectValue("x0_no_bypass", 64'h0);
    checkOutput({32'd0, rdata[31:0]});
    cycle();
    applyStimulus(1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    #1;
    expectValue("x0_after_write", 64'h0);
    checkOutput({32'd0, rdata[31:0]});

    // Bypass: both ports see the in-flight value, then the stored one.
    applyStimulus(1'b1, 5'd3, 32'h11, 5'd0, 5'd0);
    cycle();
    applyStimulus(1'b0, 5'd0, 32'h0, 5'd3, 5'd3);
    #1;
    expectValue("x3_before_bypass", 64'h11);
    checkOutput({32'd0, rdata[31:0]});
    applyStimulus(1'b1, 5'd3, 32'h22, 5'd3, 5'd3);
    #1;
    expectValue("bypass_p0", 64'h22);
    expectValue("bypass_p1", 64'h22);
    checkOutput({32'd0, rdata[31:0]});
    checkOutput({32'd0, rdata[63:32]});
    cycle();
    applyStimulus(1'b0, 5'd0, 32'h0, 5'd3, 5'd3);
    #1;
    expectValue("after_bypass_p0", 64'h22);
    expectValue("after_bypass_p1", 64'h22);
    checkOutput({32'd0, rdata[31:0]});
    checkOutput({32'd0, rdata[63:32]});

    // Wide instance: three ports on the same address.
    we3    = 1'b1;
    waddr3 = 4'd15;
    wdata3 = 64'h0123456789ABCDEF;
    cycle();
    we3    = 1'b0;
    raddr3 = {4'd15, 4'd15, 4'd15};
    #1;
    for (int p = 0; p < 3; p++) begin
      expectValue($sformatf("wide_x15_p%0d", p), 64'h0123456789ABCDEF);
      checkOutput(rdata3[p*64 +: 64]);
    end

`ifdef RF_SCOREBOARD_EN
    // Scoreboard set, write-clear, set-wins and x0 cases.
    applyStimulus(1'b0, 5'd0, 32'h0, 5'd9, 5'd0);
    sbSet  = 1'b1;
    sbAddr = 5'd9;
    #1;
    expectValue("pend9_before_set", 64'd0);
    checkOutput({63'd0, rdPending[0]});
    cycle();
    sbSet = 1'b0;
    #1;
    expectValue("pend9_after_set", 64'd1);
    checkOutput({63'd0, rdPending[0]});
    applyStimulus(1'b1, 5'd9, 32'h99, 5'd9, 5'd0);
    #1;
    expectValue("pend9_inflight", 64'd0);
    checkOutput({63'd0, rdPending[0]});
    cycle();
    applyStimulus(1'b0, 5'd0, 32'h0, 5'd9, 5'd0);
    #1;
    expectValue("pend9_after_write", 64'd0);
    checkOutput({63'd0, rdPending[0]});
    applyStimulus(1'b1, 5'd9, 32'h98, 5'd9, 5'd0);
    sbSet  = 1'b1;
    sbAddr = 5'd9;
    cycle();
    applyStimulus(1'b0, 5'd0, 32'h0, 5'd9, 5'd0);
    sbSet = 1'b0;
    #1;
    expectValue("pend9_set_wins", 64'd1);
    checkOutput({63'd0, rdPending[0]});
    sbSet  = 1'b1;
    sbAddr = 5'd0;
    cycle();
    sbSet = 1'b0;
    #1;
    expectValue("pend0_never", 64'd0);
    checkOutput({63'd0, rdPending[1]});
`endif

    // Mid-clear reset: restart at clr_idx=10 and require the full walk again.
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    repeat (9) cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    expectValue("restart_init_done", 64'd0);
    checkOutput({63'd0, initDone});
    for (int k = 1; k <= 31; k++) begin
      expectValue($sformatf("reclear_init_done_edge%0d", k), (k >= 31) ? 64'd1 : 64'd0);
      cycle();
      checkOutput({63'd0, initDone});
    end
    applyStimulus(1'b0, 5'd0, 32'h0, 5'd3, 5'd7);
    #1;
    expectValue("x3_after_reclear", 64'h0);
    expectValue("x7_after_reclear", 64'h0);
    checkOutput({32'd0, rdata[31:0]});
    checkOutput({32'd0, rdata[63:32]});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
